// File: rtl/lsu_pkg.sv
// Shared encodings for the byte-serial load/store sequencer and its helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Index of the final byte of an access; only meaningful for legal sizes.
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    logic [2:0] n;
    n = size_bytes(size) - 3'd1;
    return n[1:0];
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Zero/sign extension of a right-justified byte, halfword or word load value.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] acc_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] result_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    result_o = acc_i;
    case (size_i)
      SZ_BYTE: result_o = {{24{signed_i & acc_i[7]}}, acc_i[7:0]};
      SZ_HALF: result_o = {{16{signed_i & acc_i[15]}}, acc_i[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Serialises byte/half/word loads and stores onto a byte-wide, registered-read
// SRAM port (big-endian), assembling and extending load results.
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_w,
  output logic              mem_w_en,
  input  logic [7:0]        mem_r
);

  state_e            state_q;
  logic [1:0]        k_q;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [23:0]       acc_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_w_q;
  logic              mem_w_en_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_rdata_q;

  logic [31:0]       acc_d;
  logic [31:0]       wdata_just;
  logic [31:0]       ext_result;

  // Read data is always one cycle behind the address, so the accumulator
  // takes mem_r as the next least-significant byte.
  assign acc_d = {acc_q, mem_r};

  // Store data is left-justified once so each write simply takes the top byte.
  always_comb begin
    wdata_just = req_wdata;
    case (req_size)
      SZ_BYTE: wdata_just = {req_wdata[7:0], 24'h0};
      SZ_HALF: wdata_just = {req_wdata[15:0], 16'h0};
      default: ;
    endcase
  end

  lsu_extend u_extend (
    .acc_i    (acc_d),
    .size_i   (size_q),
    .signed_i (signed_q),
    .result_o (ext_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      base_q       <= '0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      wdata_q      <= 32'h0;
      acc_q        <= 24'h0;
      mem_addr_q   <= '0;
      mem_w_q      <= 8'h0;
      mem_w_en_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            base_q   <= req_addr;
            size_q   <= req_size;
            signed_q <= req_signed;
            k_q      <= 2'd0;
            acc_q    <= 24'h0;
            if (req_size == SZ_ILLEGAL) begin
              state_q <= ST_ERR;
            end else if (req_we) begin
              state_q    <= ST_WRITE;
              mem_w_en_q <= 1'b1;
              mem_addr_q <= req_addr;
              mem_w_q    <= wdata_just[31:24];
              wdata_q    <= {wdata_just[23:0], 8'h0};
            end else begin
              state_q    <= ST_READ;
              mem_addr_q <= req_addr;
            end
          end
        end

        ST_READ: begin
          if (k_q != 2'd0) acc_q <= acc_d[23:0];
          if (k_q == last_idx(size_q)) begin
            state_q    <= ST_DRAIN;
            mem_addr_q <= '0;
          end else begin
            k_q        <= k_q + 2'd1;
            mem_addr_q <= base_q + ADDR_W'(k_q + 2'd1);
          end
        end

        ST_DRAIN: begin
          acc_q        <= acc_d[23:0];
          k_q          <= 2'd0;
          resp_rdata_q <= ext_result;
          resp_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end

        ST_WRITE: begin
          if (k_q == last_idx(size_q)) begin
            state_q      <= ST_IDLE;
            k_q          <= 2'd0;
            mem_w_en_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_q      <= 8'h0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= 32'h0;
          end else begin
            k_q        <= k_q + 2'd1;
            mem_addr_q <= base_q + ADDR_W'(k_q + 2'd1);
            mem_w_q    <= wdata_q[31:24];
            wdata_q    <= {wdata_q[23:0], 8'h0};
          end
        end

        ST_ERR: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_rdata_q <= 32'h0;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A reset arriving mid-store must also suppress the write already on the
  // port in that cycle, so the enable is masked by rst directly.
  assign mem_w_en   = mem_w_en_q & ~rst;
  assign mem_addr   = mem_addr_q;
  assign mem_w      = mem_w_q;
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench: byte-array SRAM with registered read, plus a byte-level
// reference model of memory contents and access timing.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_w;
  logic        mem_w_en;
  logic [7:0]  mem_r;

  logic [7:0]  sram    [256];
  logic [7:0]  ref_mem [256];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_byte_seq #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_w      (mem_w),
    .mem_w_en   (mem_w_en),
    .mem_r      (mem_r)
  );

  always @(posedge clk) begin
    if (mem_w_en) sram[mem_addr] <= mem_w;
    mem_r <= sram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [7:0] addr);
    int          n;
    logic [31:0] v;
    logic [7:0]  a;
    n = nbytes(size);
    v = 32'h0;
    for (int k = 0; k < n; k++) begin
      a = addr + 8'(k);
      v = (v << 8) | 32'(ref_mem[a]);
    end
    if (sgn && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [7:0] store_byte(input logic [31:0] wdata, input int n, input int k);
    return 8'(wdata >> (8 * (n - 1 - k)));
  endfunction

  task automatic scramble_inputs();
    req_valid  = 1'($urandom_range(0, 1));
    req_we     = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = 8'($urandom);
    req_wdata  = $urandom;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge in the cycle that will accept; returns at the negedge
  // of the response cycle so the next call is back-to-back.
  task automatic run_op(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got);
    int          n;
    int          rc;
    logic [31:0] exp;
    logic [7:0]  a;
    n = nbytes(size);
    if (size == 2'd3) begin
      rc = 2; exp = 32'h0;
    end else if (we) begin
      rc = n + 1; exp = 32'h0;
    end else begin
      rc = n + 2; exp = model_load(size, sgn, addr);
    end
    check("accept_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    for (int c = 1; c <= rc; c++) begin
      @(negedge clk);
      a = addr + 8'(c - 1);
      if (c < rc) begin
        check("busy_valid", 32'(resp_valid), 32'd0);
        check("busy_ready", 32'(req_ready), 32'd0);
        if (size != 2'd3 && c <= n) begin
          check("addr", 32'(mem_addr), 32'(a));
          check("w_en", 32'(mem_w_en), 32'(we));
          if (we) check("w_data", 32'(mem_w), 32'(store_byte(wdata, n, c - 1)));
        end else begin
          check("quiet_w_en", 32'(mem_w_en), 32'd0);
        end
        scramble_inputs();
      end else begin
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_err", 32'(resp_err), 32'(size == 2'd3));
        check("resp_rdata", resp_rdata, exp);
        check("resp_ready", 32'(req_ready), 32'd1);
        check("idle_w_en", 32'(mem_w_en), 32'd0);
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_w", 32'(mem_w), 32'd0);
      end
    end
    if (we && size != 2'd3)
      for (int k = 0; k < n; k++) ref_mem[8'(addr + 8'(k))] = store_byte(wdata, n, k);
    got = resp_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic        we;
    logic [1:0]  sz;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 8'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_w_en", 32'(mem_w_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_w", 32'(mem_w), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Initialise every byte of memory through the DUT so the model is exact.
    for (int i = 0; i < 64; i++) run_op(1'b1, 2'd2, 1'b0, 8'(4 * i), 32'h0, got);

    run_op(1'b1, 2'd2, 1'b0, 8'h00, 32'h11223344, got);
    run_op(1'b0, 2'd2, 1'b0, 8'h00, 32'h0, got);
    check("word0", got, 32'h11223344);

    run_op(1'b1, 2'd0, 1'b0, 8'h06, 32'h80, got);
    run_op(1'b1, 2'd0, 1'b0, 8'h07, 32'hFF, got);
    run_op(1'b0, 2'd0, 1'b1, 8'h06, 32'h0, got);
    check("byte_signed", got, 32'hFFFFFF80);
    run_op(1'b0, 2'd0, 1'b0, 8'h06, 32'h0, got);
    check("byte_unsigned", got, 32'h00000080);
    run_op(1'b0, 2'd1, 1'b1, 8'h06, 32'h0, got);
    check("half_signed", got, 32'hFFFF80FF);

    run_op(1'b1, 2'd2, 1'b0, 8'h08, 32'h55667788, got);
    run_op(1'b1, 2'd1, 1'b0, 8'h0A, 32'h0000ABCD, got);
    run_op(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, got);
    check("half_merge", got, 32'h5566ABCD);

    run_op(1'b1, 2'd2, 1'b0, 8'hFE, 32'h01020304, got);
    run_op(1'b0, 2'd2, 1'b0, 8'hFE, 32'h0, got);
    check("wrap_word", got, 32'h01020304);

    run_op(1'b0, 2'd3, 1'b0, 8'h20, 32'hFFFFFFFF, got);
    check("err_rdata", got, 32'h0);
    run_op(1'b0, 2'd0, 1'b0, 8'h06, 32'h0, got);
    check("after_err_byte", got, 32'h00000080);

    // Reset in cycle 2 of a word store: only the first byte lands.
    run_op(1'b1, 2'd2, 1'b0, 8'h10, 32'h0, got);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 8'h10; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rst_op_w_en1", 32'(mem_w_en), 32'd1);
    check("rst_op_w1", 32'(mem_w), 32'hDE);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_op_w_en2", 32'(mem_w_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_op_ready", 32'(req_ready), 32'd1);
    check("rst_op_rdata", resp_rdata, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check("rst_op_no_valid", 32'(resp_valid), 32'd0);
      check("rst_op_no_w_en", 32'(mem_w_en), 32'd0);
      idle_cycle();
    end
    ref_mem[8'h10] = 8'hDE;
    run_op(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, got);
    check("rst_op_word", got, 32'hDE000000);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      run_op(we, sz, 1'($urandom_range(0, 1)), 8'($urandom), $urandom, got);
    end

    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
